hadamard_out_serializer: RTL and testbench

Downstream stage of the complex Hadamard/twiddle butterfly. Captures the four complex SFP results that the butterfly presents on its done pulse. Buffers up to two such result vectors in a ping-pong store. Drains them one complex lane per cycle over a valid/ready stream toward the next FFT stage or the result memory.

---
 rtl/hadamard_out_serializer.sv | 143 ++++++++++++++
 tb/tb_hadamard_out_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hadamard_out_serializer.sv
// hadamard_out_serializer
// Captures the four complex SFP lanes that the butterfly presents on hadamard_done.
// Holds up to two such vectors in a ping-pong store and drains them one lane per
// cycle over a valid/ready stream.
// Optional feature macro: HADAMARD_SER_BITREV_EN. When it is defined, lanes are
// emitted in bit-reversed order (0,2,1,3). When it is undefined, the order is 0,1,2,3.
module hadamard_out_serializer #(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hadamard_done,
    input  logic [formatWidth*4-1:0] in_real,
    input  logic [formatWidth*4-1:0] in_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [formatWidth-1:0]   out_real,
    output logic [formatWidth-1:0]   out_imag,
    output logic [1:0]               out_lane,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overflow
);

    localparam int W = formatWidth;

    // Ping-pong store: two entries of four complex lanes each.
    logic [W-1:0] mem_real [0:1][0:3];
    logic [W-1:0] mem_imag [0:1][0:3];

    // Input vectors unpacked into per-lane words.
    logic [W-1:0] in_real_lane [0:3];
    logic [W-1:0] in_imag_lane [0:3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign in_real_lane[gi] = in_real[W*gi +: W];
            assign in_imag_lane[gi] = in_imag[W*gi +: W];
        end
    endgenerate

    // Control state.
    logic         wp_reg, wp_next;
    logic         rp_reg, rp_next;
    logic [1:0]   count_reg, count_next;
    logic [1:0]   lane_reg, lane_next;
    logic         overflow_reg, overflow_next;
    logic [W-1:0] out_real_reg, out_real_next;
    logic [W-1:0] out_imag_reg, out_imag_next;

    logic         transfer;
    logic         pop;
    logic         capture;
    logic [1:0]   sel_next;

    // The internal counter always runs 0..3. Only the physical lane it selects changes.
    function automatic logic [1:0] lane_map(input logic [1:0] l);
`ifdef HADAMARD_SER_BITREV_EN
        return {l[0], l[1]};
`else
        return l;
`endif
    endfunction

    assign out_valid = (count_reg != 2'd0);
    assign transfer  = out_valid & out_ready;
    assign pop       = transfer & (lane_reg == 2'd3);
    // A full store still accepts a strobe when the pop frees an entry on the same edge.
    assign capture   = hadamard_done & ((count_reg != 2'd2) | pop);

    // Next-state logic. Output data is preloaded for whatever entry and lane will be
    // current after this edge. This lets a fresh capture appear on the very next cycle.
    always_comb begin
        count_next    = count_reg;
        rp_next       = rp_reg ^ pop;
        wp_next       = wp_reg ^ capture;
        lane_next     = transfer ? (lane_reg + 2'd1) : lane_reg;
        overflow_next = overflow_reg | (hadamard_done & (count_reg == 2'd2) & ~pop);
        out_real_next = '0;
        out_imag_next = '0;

        if (capture && !pop)
            count_next = count_reg + 2'd1;
        else if (pop && !capture)
            count_next = count_reg - 2'd1;

        sel_next = lane_map(lane_next);

        if (count_next != 2'd0) begin
            // The entry being written this edge is not yet in storage, so it is
            // taken straight from the inputs.
            if (capture && (wp_reg == rp_next)) begin
                out_real_next = in_real_lane[sel_next];
                out_imag_next = in_imag_lane[sel_next];
            end else begin
                out_real_next = mem_real[rp_next][sel_next];
                out_imag_next = mem_imag[rp_next][sel_next];
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg       <= 1'b0;
            rp_reg       <= 1'b0;
            count_reg    <= 2'd0;
            lane_reg     <= 2'd0;
            overflow_reg <= 1'b0;
            out_real_reg <= '0;
            out_imag_reg <= '0;
        end else begin
            wp_reg       <= wp_next;
            rp_reg       <= rp_next;
            count_reg    <= count_next;
            lane_reg     <= lane_next;
            overflow_reg <= overflow_next;
            out_real_reg <= out_real_next;
            out_imag_reg <= out_imag_next;
        end
    end

    // Storage write on an accepted capture. Contents need no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                mem_real[wp_reg][i] <= in_real_lane[i];
                mem_imag[wp_reg][i] <= in_imag_lane[i];
            end
        end
    end

    assign out_real = out_real_reg;
    assign out_imag = out_imag_reg;
    assign out_lane = lane_map(lane_reg);
    assign out_last = out_valid & (lane_reg == 2'd3);
    assign busy     = (count_reg == 2'd2);
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_hadamard_out_serializer.sv
// Scoreboard bench for hadamard_out_serializer.
// The driver decides from a queue-level model whether each strobe is accepted and
// stages the expected lanes. The monitor compares every cycle against the queue head.
module tb_hadamard_out_serializer;

    localparam int W = 9;

    logic           clk;
    logic           rst;
    logic           hadamard_done;
    logic [W*4-1:0] in_real;
    logic [W*4-1:0] in_imag;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_real;
    logic [W-1:0]   out_imag;
    logic [1:0]     out_lane;
    logic           out_last;
    logic           busy;
    logic           overflow;

    hadamard_out_serializer #(.expWidth(4), .sigWidth(4), .formatWidth(W)) dut (
        .clk(clk), .rst(rst), .hadamard_done(hadamard_done),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_lane(out_lane), .out_last(out_last),
        .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [1:0]   lane;
        logic         last;
    } exp_t;

    exp_t           exp_q[$];
    int             total_checks  = 0;
    int             passed_checks = 0;
    logic           ovf_model     = 1'b0;
    logic           in_reset      = 1'b1;
    logic           stage_valid   = 1'b0;
    logic           stage_ovf     = 1'b0;
    logic [W*4-1:0] stage_re;
    logic [W*4-1:0] stage_im;

`ifdef HADAMARD_SER_BITREV_EN
    int ord [4] = '{0, 2, 1, 3};
`else
    int ord [4] = '{0, 1, 2, 3};
`endif

    function automatic void chk(input string name, input int act, input int req);
        total_checks++;
        if (act == req)
            passed_checks++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endfunction

    function automatic logic [W*4-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W*4-1:0];
    endfunction

    // One cycle of stimulus. A strobe is accepted when fewer than two vectors are
    // pending, or when the head vector finishes on this very edge.
    task automatic cycle(input logic strobe, input logic rdy,
                         input logic [W*4-1:0] re, input logic [W*4-1:0] im);
        int  size;
        int  cnt;
        logic pops;
        @(negedge clk);
        out_ready     = rdy;
        hadamard_done = strobe;
        in_real       = re;
        in_imag       = im;
        if (strobe) begin
            size = exp_q.size();
            cnt  = (size + 3) / 4;
            pops = rdy && (size > 0) && (size % 4 == 1);
            if (cnt < 2 || pops) begin
                stage_valid = 1'b1;
                stage_re    = re;
                stage_im    = im;
            end else begin
                stage_ovf = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, rdy, '0, '0);
    endtask

    task automatic strobe_rand(input logic rdy);
        cycle(1'b1, rdy, rand_vec(), rand_vec());
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_real"},  int'(out_real),  0);
        chk({tag, "_imag"},  int'(out_imag),  0);
        chk({tag, "_lane"},  int'(out_lane),  0);
        chk({tag, "_last"},  int'(out_last),  0);
        chk({tag, "_busy"},  int'(busy),      0);
        chk({tag, "_ovf"},   int'(overflow),  0);
    endtask

    // Asynchronous reset asserted mid-cycle; the outputs must clear without a clock edge.
    task automatic reset_mid(input string tag);
        @(negedge clk);
        in_reset      = 1'b1;
        hadamard_done = 1'b0;
        #1 rst = 1'b1;
        #1 check_zero_outputs(tag);
        exp_q.delete();
        ovf_model   = 1'b0;
        stage_valid = 1'b0;
        stage_ovf   = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        in_reset = 1'b0;
    endtask

    // Monitor: check the presented lane against the scoreboard head every cycle.
    initial begin
        exp_t e;
        int   size;
        forever begin
            @(negedge clk);
            #2;
            if (!in_reset) begin
                size = exp_q.size();
                chk("valid", int'(out_valid), int'(size > 0));
                chk("busy", int'(busy), int'((size + 3) / 4 == 2));
                chk("overflow", int'(overflow), int'(ovf_model));
                if (size > 0) begin
                    e = exp_q[0];
                    chk("real", int'(out_real), int'(e.re));
                    chk("imag", int'(out_imag), int'(e.im));
                    chk("lane", int'(out_lane), int'(e.lane));
                    chk("last", int'(out_last), int'(e.last));
                    if (out_ready) begin
                        $display("xfer lane=%0d real=%03h imag=%03h last=%0d",
                                 out_lane, out_real, out_imag, out_last);
                        void'(exp_q.pop_front());
                    end
                end else begin
                    chk("last_idle", int'(out_last), 0);
                end
                if (stage_valid) begin
                    for (int j = 0; j < 4; j++) begin
                        e.re   = stage_re[W*ord[j] +: W];
                        e.im   = stage_im[W*ord[j] +: W];
                        e.lane = 2'(ord[j]);
                        e.last = (j == 3);
                        exp_q.push_back(e);
                    end
                    stage_valid = 1'b0;
                end
                if (stage_ovf) begin
                    ovf_model = 1'b1;
                    stage_ovf = 1'b0;
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        hadamard_done = 1'b0;
        out_ready     = 1'b0;
        in_real       = '0;
        in_imag       = '0;
        #3 check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_reset = 1'b0;

        // Single vector with known lane data, consumer always ready.
        cycle(1'b1, 1'b1, {9'h004, 9'h003, 9'h002, 9'h001}, {9'h014, 9'h013, 9'h012, 9'h011});
        idle(1'b1, 6);

        // Backpressure with out_ready pattern 1,0,0,1.
        strobe_rand(1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, (i % 4 == 0) || (i % 4 == 3), '0, '0);
        idle(1'b1, 4);

        // Full store, and a strobe coinciding with the lane-3 pop.
        strobe_rand(1'b0);
        idle(1'b0, 1);
        strobe_rand(1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);
        strobe_rand(1'b1);
        idle(1'b1, 14);

        // Fill, then a third strobe is dropped and sets overflow.
        strobe_rand(1'b0);
        strobe_rand(1'b0);
        idle(1'b0, 2);
        strobe_rand(1'b0);
        idle(1'b0, 2);
        idle(1'b1, 10);

        // Reset while lane 1 is presented; nothing must come out afterwards.
        cycle(1'b1, 1'b1, rand_vec(), rand_vec());
        idle(1'b1, 1);
        reset_mid("midrst");
        idle(1'b1, 6);

        // Sustained strobe every 4 cycles with out_ready high must never overflow.
        for (int v = 0; v < 6; v++) begin
            strobe_rand(1'b1);
            idle(1'b1, 3);
        end
        idle(1'b1, 4);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, rand_vec(), rand_vec());

        // Bounded drain.
        for (int i = 0; i < 50 && (exp_q.size() > 0 || stage_valid); i++) idle(1'b1, 1);
        idle(1'b1, 2);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
